// File: rtl/stopwatch_timer_core_if.sv
// Control-pulse and display bundle between the button debouncers, the
// stopwatch/timer core and the 7-segment multiplexer.
interface stopwatch_timer_core_if;
  logic       en;
  logic       start_p;
  logic       stop_p;
  logic       clr_p;
  logic       inc_min_p;
  logic       inc_sec_p;
  logic       lap_p;
  logic       mode;
  logic [3:0] min_tens;
  logic [3:0] min_ones;
  logic [3:0] sec_tens;
  logic [3:0] sec_ones;
  logic       running;
  logic       lap_active;
  logic       alarm;
  logic       tick;

  modport master (
    output en, start_p, stop_p, clr_p, inc_min_p, inc_sec_p, lap_p, mode,
    input  min_tens, min_ones, sec_tens, sec_ones, running, lap_active, alarm, tick
  );

  modport slave (
    input  en, start_p, stop_p, clr_p, inc_min_p, inc_sec_p, lap_p, mode,
    output min_tens, min_ones, sec_tens, sec_ones, running, lap_active, alarm, tick
  );
endinterface

// File: rtl/stopwatch_timer_core.sv
// MM:SS count-up stopwatch / count-down timer with alarm and lap display hold.
// Every output is registered from the next-state values, so a pulse shows up one cycle later.
module stopwatch_timer_core #(
  parameter int TICK_DIV = 25_000_000,
  parameter int MAX_MIN  = 59
) (
  input  logic                    clk,
  input  logic                    rst_n,
  stopwatch_timer_core_if.slave   bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_ALARM} state_t;

  localparam int             PW      = $clog2(TICK_DIV);
  localparam logic [PW-1:0]  PRE_TOP = PW'(TICK_DIV - 1);
  localparam logic [6:0]     MIN_TOP = 7'(MAX_MIN);

  state_t         r_state, w_state;
  logic [6:0]     r_min, w_min, r_hold_min, w_hold_min;
  logic [5:0]     r_sec, w_sec, r_hold_sec, w_hold_sec;
  logic [PW-1:0]  r_pre, w_pre;
  logic           r_dir, w_dir;
  logic           r_lap, w_lap;
  logic           w_tick, w_adv;
  logic [6:0]     w_disp_min;
  logic [5:0]     w_disp_sec;
  logic [7:0]     w_bcd_min, w_bcd_sec;

  logic [15:0]    r_digits;
  logic           r_running, r_alarm, r_tick;

  function automatic logic [7:0] to_bcd(input logic [6:0] v);
    logic [6:0] t;
    t = v / 7'd10;
    return {4'(t), 4'(v - t * 7'd10)};
  endfunction

  always_comb begin
    w_state    = r_state;
    w_min      = r_min;
    w_sec      = r_sec;
    w_pre      = r_pre;
    w_dir      = r_dir;
    w_lap      = r_lap;
    w_hold_min = r_hold_min;
    w_hold_sec = r_hold_sec;
    w_tick     = 1'b0;
    w_adv      = 1'b0;

    // Only the highest-priority asserted pulse is acted on; the prescaler
    // keeps running in RUN unless that pulse is clr or stop.
    if (bus.clr_p) begin
      w_state = S_IDLE;
      w_min   = '0;
      w_sec   = '0;
      w_pre   = '0;
      w_lap   = 1'b0;
    end else if (bus.stop_p) begin
      if (r_state == S_RUN) w_state = S_PAUSE;
    end else begin
      w_adv = (r_state == S_RUN);
      if (bus.start_p) begin
        case (r_state)
          S_IDLE: begin
            if (!(bus.mode && r_min == '0 && r_sec == '0)) begin
              w_state = S_RUN;
              w_dir   = bus.mode;
              w_pre   = '0;
            end
          end
          S_PAUSE: begin
            if (!(r_dir && r_min == '0 && r_sec == '0)) w_state = S_RUN;
          end
          S_ALARM: w_state = S_IDLE;
          default: ;
        endcase
      end else if (bus.lap_p) begin
        if (r_state == S_RUN) begin
          w_lap = ~r_lap;
          if (!r_lap) begin
            w_hold_min = r_min;
            w_hold_sec = r_sec;
          end
        end else begin
          w_lap = 1'b0;
        end
      end else if (r_state == S_IDLE || r_state == S_PAUSE) begin
        if (bus.inc_sec_p) w_sec = (r_sec == 6'd59) ? '0 : r_sec + 6'd1;
        if (bus.inc_min_p) w_min = (r_min == MIN_TOP) ? '0 : r_min + 7'd1;
      end
    end

    if (w_adv) begin
      if (r_pre == PRE_TOP) begin
        w_pre  = '0;
        w_tick = 1'b1;
        if (!r_dir) begin
          if (r_sec == 6'd59) begin
            w_sec = '0;
            w_min = (r_min == MIN_TOP) ? '0 : r_min + 7'd1;
          end else begin
            w_sec = r_sec + 6'd1;
          end
        end else begin
          if (r_sec == '0) begin
            w_sec = 6'd59;
            w_min = r_min - 7'd1;
          end else begin
            w_sec = r_sec - 6'd1;
          end
          if (r_min == '0 && r_sec == 6'd1) w_state = S_ALARM;
        end
      end else begin
        w_pre = r_pre + PW'(1);
      end
    end
  end

  assign w_disp_min = w_lap ? w_hold_min : w_min;
  assign w_disp_sec = w_lap ? w_hold_sec : w_sec;
  assign w_bcd_min  = to_bcd(w_disp_min);
  assign w_bcd_sec  = to_bcd({1'b0, w_disp_sec});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_min      <= '0;
      r_sec      <= '0;
      r_pre      <= '0;
      r_dir      <= 1'b0;
      r_lap      <= 1'b0;
      r_hold_min <= '0;
      r_hold_sec <= '0;
      r_digits   <= '0;
      r_running  <= 1'b0;
      r_alarm    <= 1'b0;
      r_tick     <= 1'b0;
    end else if (bus.en) begin
      r_state    <= w_state;
      r_min      <= w_min;
      r_sec      <= w_sec;
      r_pre      <= w_pre;
      r_dir      <= w_dir;
      r_lap      <= w_lap;
      r_hold_min <= w_hold_min;
      r_hold_sec <= w_hold_sec;
      r_digits   <= {w_bcd_min, w_bcd_sec};
      r_running  <= (w_state == S_RUN);
      r_alarm    <= (w_state == S_ALARM);
      r_tick     <= w_tick;
    end
  end

  assign bus.min_tens   = r_digits[15:12];
  assign bus.min_ones   = r_digits[11:8];
  assign bus.sec_tens   = r_digits[7:4];
  assign bus.sec_ones   = r_digits[3:0];
  assign bus.running    = r_running;
  assign bus.lap_active = r_lap;
  assign bus.alarm      = r_alarm;
  assign bus.tick       = r_tick;

endmodule

// File: tb/tb_stopwatch_timer_core.sv
// Bench for stopwatch_timer_core: directed scenarios plus random pulses,
// compared against a seconds-count reference model.
module tb_stopwatch_timer_core;
  localparam int TD   = 4;
  localparam int MM   = 2;
  localparam int SPAN = (MM + 1) * 60;
  localparam int ST_IDLE = 0, ST_RUN = 1, ST_PAUSE = 2, ST_ALARM = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  stopwatch_timer_core_if bus();

  stopwatch_timer_core #(.TICK_DIV(TD), .MAX_MIN(MM)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  int m_st, m_tot, m_pre, m_dir, m_lap, m_hold, m_tick;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_st = ST_IDLE; m_tot = 0; m_pre = 0; m_dir = 0; m_lap = 0; m_hold = 0; m_tick = 0;
  endfunction

  // One clock edge of behaviour, expressed on a total-seconds count.
  function automatic void model_step();
    int was_run, mm, ss;
    if (!bus.en) return;
    m_tick  = 0;
    was_run = (m_st == ST_RUN);
    if (bus.clr_p) begin
      m_st = ST_IDLE; m_tot = 0; m_pre = 0; m_lap = 0;
      return;
    end
    if (bus.stop_p) begin
      if (m_st == ST_RUN) m_st = ST_PAUSE;
      return;
    end
    if (bus.start_p) begin
      if (m_st == ST_IDLE && !(bus.mode && m_tot == 0)) begin
        m_st = ST_RUN; m_dir = int'(bus.mode); m_pre = 0;
      end else if (m_st == ST_PAUSE && !(m_dir == 1 && m_tot == 0)) begin
        m_st = ST_RUN;
      end else if (m_st == ST_ALARM) begin
        m_st = ST_IDLE;
      end
    end else if (bus.lap_p) begin
      if (m_st == ST_RUN) begin
        if (m_lap == 0) m_hold = m_tot;
        m_lap = 1 - m_lap;
      end else begin
        m_lap = 0;
      end
    end else if (m_st == ST_IDLE || m_st == ST_PAUSE) begin
      mm = m_tot / 60; ss = m_tot % 60;
      if (bus.inc_sec_p) ss = (ss + 1) % 60;
      if (bus.inc_min_p) mm = (mm + 1) % (MM + 1);
      m_tot = mm * 60 + ss;
    end
    if (was_run) begin
      if (m_pre == TD - 1) begin
        m_pre  = 0;
        m_tick = 1;
        if (m_dir == 0) m_tot = (m_tot + 1) % SPAN;
        else begin
          m_tot = m_tot - 1;
          if (m_tot == 0) m_st = ST_ALARM;
        end
      end else begin
        m_pre++;
      end
    end
  endfunction

  function automatic logic [15:0] exp_digits();
    int d, mm, ss;
    d = (m_lap != 0) ? m_hold : m_tot;
    mm = d / 60; ss = d % 60;
    return 16'(((mm / 10) << 12) | ((mm % 10) << 8) | ((ss / 10) << 4) | (ss % 10));
  endfunction

  function automatic logic [3:0] exp_flags();
    return {m_st == ST_RUN, m_lap != 0, m_st == ST_ALARM, m_tick != 0};
  endfunction

  function automatic logic [15:0] dut_digits();
    return {bus.min_tens, bus.min_ones, bus.sec_tens, bus.sec_ones};
  endfunction

  function automatic logic [3:0] dut_flags();
    return {bus.running, bus.lap_active, bus.alarm, bus.tick};
  endfunction

  task automatic clear_pulses();
    bus.start_p = 0; bus.stop_p = 0; bus.clr_p = 0; bus.inc_min_p = 0;
    bus.inc_sec_p = 0; bus.lap_p = 0;
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) model_step();
    #1;
    chk("digits", dut_digits(), exp_digits());
    chk("flags", dut_flags(), exp_flags());
    clear_pulses();
  endtask

  task automatic wait_tot(input int target, input string tag);
    int n = 0;
    while (m_tot != target && n < 400) begin
      step();
      n++;
    end
    if (m_tot != target) chk(tag, 32'(n), 32'd0);
  endtask

  task automatic do_clr();     bus.clr_p = 1;     step(); endtask
  task automatic do_start();   bus.start_p = 1;   step(); endtask
  task automatic do_stop();    bus.stop_p = 1;    step(); endtask
  task automatic do_lap();     bus.lap_p = 1;     step(); endtask
  task automatic do_inc_min(); bus.inc_min_p = 1; step(); endtask
  task automatic do_inc_sec(); bus.inc_sec_p = 1; step(); endtask

  initial begin
    bus.en = 1; bus.mode = 0;
    clear_pulses();
    model_reset();
    #12;
    chk("rst_digits", dut_digits(), 16'h0000);
    chk("rst_flags", dut_flags(), 4'b0000);
    rst_n = 1;

    // Setting the count in IDLE
    do_inc_min();
    repeat (3) do_inc_sec();
    chk("inc_digits", dut_digits(), 16'h0103);
    chk("inc_idle_running", bus.running, 1'b0);

    // Count-up wrap at MAX_MIN:59
    do_clr();
    repeat (2) do_inc_min();
    repeat (58) do_inc_sec();
    chk("set_258", dut_digits(), 16'h0258);
    bus.mode = 0;
    do_start();
    chk("up_running", bus.running, 1'b1);
    repeat (4) step();
    chk("up_259", dut_digits(), 16'h0259);
    chk("up_tick", bus.tick, 1'b1);
    repeat (4) step();
    chk("up_wrap", dut_digits(), 16'h0000);
    chk("up_wrap_flags", {bus.running, bus.alarm}, 2'b10);

    // Countdown into alarm
    do_clr();
    repeat (2) do_inc_sec();
    bus.mode = 1;
    do_start();
    repeat (4) step();
    chk("dn_001", dut_digits(), 16'h0001);
    repeat (4) step();
    chk("dn_000", dut_digits(), 16'h0000);
    chk("dn_alarm", {bus.running, bus.alarm}, 2'b01);
    do_start();
    chk("alarm_clear", {bus.running, bus.alarm}, 2'b00);

    // Pause keeps the prescaler; lap freezes the display
    do_clr();
    bus.mode = 0;
    do_start();
    repeat (2) step();
    do_stop();
    repeat (3) step();
    chk("paused", bus.running, 1'b0);
    do_start();
    step();
    chk("resume_no_tick", bus.tick, 1'b0);
    step();
    chk("resume_tick", bus.tick, 1'b1);
    wait_tot(5, "wait_005");
    do_lap();
    chk("lap_on", bus.lap_active, 1'b1);
    wait_tot(7, "wait_007");
    chk("lap_frozen", dut_digits(), 16'h0005);
    do_lap();
    chk("lap_off", dut_digits(), 16'h0007);

    // Priority and edge cases
    bus.clr_p = 1; bus.start_p = 1; step();
    chk("clr_over_start", {bus.running, dut_digits()}, {1'b0, 16'h0000});
    do_start();
    do_inc_sec();
    chk("inc_in_run", dut_digits(), 16'h0000);
    do_clr();
    bus.mode = 1;
    do_start();
    chk("dn_start_zero", bus.running, 1'b0);
    bus.en = 0; bus.mode = 0;
    do_start();
    chk("en_low_start", bus.running, 1'b0);
    bus.en = 1;
    step();

    // Asynchronous reset mid-cycle while running with lap active
    do_inc_min();
    repeat (30) do_inc_sec();
    do_start();
    do_lap();
    chk("pre_rst", {bus.running, bus.lap_active, dut_digits()}, {2'b11, 16'h0130});
    #3 rst_n = 0;
    #1;
    model_reset();
    chk("async_rst_digits", dut_digits(), 16'h0000);
    chk("async_rst_flags", dut_flags(), 4'b0000);
    @(posedge clk);
    #1 rst_n = 1;
    do_inc_min();
    chk("post_rst", {bus.running, dut_digits()}, {1'b0, 16'h0100});

    // Random pulses against the reference model
    for (int i = 0; i < 4000; i++) begin
      bus.en        = ($urandom_range(0, 15) != 0);
      bus.mode      = $urandom_range(0, 1) != 0;
      bus.clr_p     = ($urandom_range(0, 79) == 0);
      bus.stop_p    = ($urandom_range(0, 29) == 0);
      bus.start_p   = ($urandom_range(0, 11) == 0);
      bus.lap_p     = ($urandom_range(0, 19) == 0);
      bus.inc_min_p = ($urandom_range(0, 9) == 0);
      bus.inc_sec_p = ($urandom_range(0, 3) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/stopwatch_timer_core.md
Name: stopwatch_timer_core

Overview:
- Parametrised successor of the stopwatch counting core: MM:SS count-up stopwatch plus count-down timer with alarm and a lap-freeze display hold.
- Sits between the button debouncers, which supply single-cycle pulses, and the 7-segment multiplexer, which consumes the BCD digits.
- Tick rate and minute range are parameters, so simulation runs with short ticks.

Parameters:
- TICK_DIV, 25_000_000, clock cycles per one-second tick (>=2).
- MAX_MIN, 59, highest minute value (1..99); minutes wrap MAX_MIN->0.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  global enable; 0 freezes prescaler and ignores all pulse inputs
- start_p  in  1  start/resume pulse, one cycle
- stop_p  in  1  pause pulse
- clr_p  in  1  soft reset pulse
- inc_min_p  in  1  minute-increment pulse
- inc_sec_p  in  1  second-increment pulse
- lap_p  in  1  lap toggle pulse
- mode  in  1  0 = count up, 1 = count down; sampled only on start from IDLE
- min_tens, min_ones, sec_tens, sec_ones  out  4 each  BCD display digits
- running  out  1  high in RUN
- lap_active  out  1  display frozen
- alarm  out  1  countdown reached 00:00
- tick  out  1  one-cycle pulse on each applied second tick

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE; count 00:00; prescaler 0; dir 0.
  - All outputs 0, including the digits.
- All outputs are registered. A pulse in cycle n takes effect at the clk edge ending cycle n and is visible in cycle n+1.
- Pulse priority within one cycle: clr_p > stop_p > start_p > lap_p > inc_*. inc_min_p and inc_sec_p together both apply.
- States and transitions:
  - IDLE -> RUN on start_p. Latches dir=mode and clears the prescaler. In down mode a start at count 00:00 is ignored and the block stays in IDLE.
  - RUN -> PAUSE on stop_p. The prescaler value is retained, so resume continues mid-second.
  - PAUSE -> RUN on start_p. dir is not re-sampled. Down mode at 00:00 is ignored.
  - RUN -> ALARM (down mode only) on the tick that produces 00:00. alarm=1 and running=0 from the next cycle.
  - ALARM -> IDLE on clr_p or start_p. Clears alarm; count stays 00:00.
  - Any state -> IDLE on clr_p. Clears count, prescaler, lap_active and alarm.
- Prescaler:
  - Increments only in RUN with en=1.
  - At TICK_DIV-1 it wraps to 0 and applies one tick. tick is asserted for that cycle.
- Count-up tick:
  - SS+1; at 59 SS wraps to 00 and MM+1.
  - At MAX_MIN:59 the count wraps to 00:00 and keeps running, with no alarm.
- Count-down tick:
  - SS-1; at 00 SS goes to 59 and MM-1.
  - Ticking to 00:00 enters ALARM.
- inc_sec_p / inc_min_p:
  - Accepted only in IDLE or PAUSE; ignored in RUN and ALARM.
  - inc_sec_p: SS+1 with 59->00 and no carry into minutes.
  - inc_min_p: MM+1 with MAX_MIN->0.
- lap_p:
  - In RUN it toggles lap_active. Setting lap_active captures the current count into the display hold register.
  - While lap_active=1 the digits show the held value and the internal count keeps advancing.
  - In PAUSE, IDLE or ALARM, lap_p only clears lap_active.
  - Clearing lap_active shows the live count next cycle.
- Digits are the BCD conversion of the displayed minute and second values: tens 0..9, ones 0..9.
- en=0:
  - All pulses are ignored, the prescaler holds and the outputs hold.
  - rst_n still acts asynchronously.
- Reset asserted mid-operation returns the block to the reset values immediately, without waiting for a clock edge.

Test Plan (TICK_DIV=4, MAX_MIN=2):
- Reset, then inc_min_p x1, inc_sec_p x3 in IDLE -> digits 0,1,0,3; state IDLE, running=0.
- Count-up wrap:
  - Set count 02:58, mode=0, start_p -> running=1.
  - After 4 cycles the count is 02:59 with one tick pulse.
  - After 4 more cycles it reads 00:00 with running still 1 and alarm=0.
- Countdown to alarm:
  - Set 00:02, mode=1, start_p -> reaches 00:01 after 4 cycles.
  - After 8 cycles total the count is 00:00, alarm=1, running=0.
  - start_p -> alarm=0, state IDLE.
- Pause and lap:
  - Up mode from 00:00, stop_p 2 cycles after start. Resume with start_p; the first tick arrives 2 cycles later (prescaler retained).
  - lap_p at 00:05 -> digits frozen at 00:05 while the internal count reaches 00:07. Second lap_p -> digits read 00:07.
- Priority and edge cases:
  - clr_p together with start_p in RUN -> IDLE with count 00:00.
  - inc_sec_p in RUN -> ignored.
  - Down-mode start_p at 00:00 -> stays IDLE.
  - With en=0, start_p -> ignored.
- Async reset:
  - Drop rst_n mid-cycle while in RUN at 01:30 with lap_active=1.
  - All outputs go to 0 before the next clk edge; operation resumes from IDLE after release.
